// File: rtl/counter_bin_struct.sv
// ---------------------------------------------------------------------------
// counter_bin_struct
//   Free-running synchronous binary up-counter. It is built from one toggle
//   flip-flop per bit and an AND-gate carry chain. Bit i toggles when every
//   lower bit is one. There is no adder.
//
// Parameters
//   WIDTH  counter width in bits (1..16); q counts modulo 2^WIDTH.
//
// Ports
//   clk  in   rising-edge clock.
//   rst  in   asynchronous, active-low clear of every bit.
//   q    out  WIDTH-bit count, taken straight from the flip-flop outputs.
//   tc   out  terminal count (q == all ones). Only present when the macro
//             COUNTERBIN_TC_EN is defined.
//
// Optional feature macro: COUNTERBIN_TC_EN
// ---------------------------------------------------------------------------

// Single toggle flip-flop with asynchronous active-low clear.
module counter_bin_struct_tff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

module counter_bin_struct #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
`ifdef COUNTERBIN_TC_EN
  ,
  output logic             tc
`endif
);

  // carry[i] is the toggle enable of bit i. It is the AND of all bits below i.
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = carry[i-1] & q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    counter_bin_struct_tff u_tff (
      .clk (clk),
      .rst (rst),
      .t   (carry[i]),
      .q   (q[i])
    );
  end

`ifdef COUNTERBIN_TC_EN
  // Decode of the registered count. Reset holds q at zero, so tc is low
  // throughout reset.
  assign tc = &q;
`endif

endmodule

// File: tb/tb_counter_bin_struct.sv
module tb_counter_bin_struct;

  logic       clk;
  logic       rst;
  logic [3:0] q4;
  logic [1:0] q2;
`ifdef COUNTERBIN_TC_EN
  logic       tc4;
  logic       tc2;
`endif

  int checks = 0;
  int fails  = 0;
  int edges;

  typedef struct {
    logic rst_val;
    int   n_edges;
    int   exp4;
    int   exp2;
  } vec_t;

  vec_t vecs[12];

  counter_bin_struct #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .q   (q4)
`ifdef COUNTERBIN_TC_EN
    ,
    .tc  (tc4)
`endif
  );

  counter_bin_struct #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .q   (q2)
`ifdef COUNTERBIN_TC_EN
    ,
    .tc  (tc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // The reference counts rising edges since the last release. Each count
  // value is that edge count taken modulo the counter size.
  task automatic check_all(input string name, input int n);
    check({name, " q4"}, int'(q4), n % 16);
    check({name, " q2"}, int'(q2), n % 4);
`ifdef COUNTERBIN_TC_EN
    check({name, " tc4"}, int'(tc4), ((n % 16) == 15) ? 1 : 0);
    check({name, " tc2"}, int'(tc2), ((n % 4) == 3) ? 1 : 0);
`endif
  endtask

  initial begin
    int pulses4, pulses2;
    vecs[0]  = '{1'b0, 0, 0, 0};
    vecs[1]  = '{1'b0, 5, 0, 0};
    vecs[2]  = '{1'b1, 1, 1, 1};
    vecs[3]  = '{1'b1, 1, 2, 2};
    vecs[4]  = '{1'b1, 1, 3, 3};
    vecs[5]  = '{1'b1, 1, 4, 0};
    vecs[6]  = '{1'b1, 11, 15, 3};
    vecs[7]  = '{1'b1, 1, 0, 0};
    vecs[8]  = '{1'b1, 4, 4, 0};
    vecs[9]  = '{1'b1, 5, 9, 1};
    vecs[10] = '{1'b0, 0, 0, 0};
    vecs[11] = '{1'b1, 1, 1, 1};

    // Power-up, then an asynchronous clear before any clock edge.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all("async reset", 0);
    @(posedge clk); #1 check_all("reset edge1", 0);
    @(posedge clk); #1 check_all("reset edge2", 0);
    @(negedge clk);

    // Table-driven vectors. Every rst change happens in the low clock phase.
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst_val;
      repeat (vecs[i].n_edges) @(posedge clk);
      #1;
      check({"vec q4 #", $sformatf("%0d", i)}, int'(q4), vecs[i].exp4);
      check({"vec q2 #", $sformatf("%0d", i)}, int'(q2), vecs[i].exp2);
`ifdef COUNTERBIN_TC_EN
      check({"vec tc4 #", $sformatf("%0d", i)}, int'(tc4), (vecs[i].exp4 == 15) ? 1 : 0);
`endif
      if (vecs[i].n_edges != 0) @(negedge clk);
    end

    // Hold reset for 5 edges and check q on every one of them.
    rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1 check_all("held reset", 0);
    end
    @(negedge clk);

    // Release. Count terminal-count pulses over 32 cycles.
    rst = 1'b1;
    pulses4 = 0;
    pulses2 = 0;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      check_all("run32", e);
`ifdef COUNTERBIN_TC_EN
      pulses4 += int'(tc4);
      pulses2 += int'(tc2);
`endif
    end
`ifdef COUNTERBIN_TC_EN
    check("tc4 pulses", pulses4, 2);
    check("tc2 pulses", pulses2, 8);
`endif
    @(negedge clk);

    // Random resets against the edge-count reference.
    rst = 1'b0;
    edges = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 19) != 0);
      if (!rst) edges = 0;
      #1 check_all("rand async", edges);
      @(posedge clk);
      if (rst) edges++;
      #1 check_all("rand edge", edges);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
